ptp_offset_servo: RTL and testbench
===================================

PTP_OFFSET_SERVO -- requirements
Module: ptp_offset_servo

Interface
REQ-001 Parameter OFFSET_W, 80, width of the signed offset from the offset calculator, in units of 2^-16 ns.
REQ-002 Parameter ADJ_W, 32, width of the signed rate adjust output.
REQ-003 Parameter STEP_THRESH_NS, 1000, offset magnitude in ns at or above which a time step is issued.
REQ-004 Parameter LOCK_THRESH_NS, 100, offset magnitude in ns below which a sample counts as in-lock.
REQ-005 Parameter LOCK_CNT, 8, consecutive in-lock samples needed to assert locked.
REQ-006 Parameter SETTLE_CNT, 2, samples discarded after a step.
REQ-007 Parameters KP_SHIFT, 2, and KI_SHIFT, 6: proportional and integral gains as arithmetic right shifts.
REQ-008 Port syc_clk_250m, input, 1, the only clock; all logic is on its rising edge.
REQ-009 Port sys_reset_n, input, 1, asynchronous, active-low reset.
REQ-010 Port servo_enable, input, 1: level; when low the servo is held idle.
REQ-011 Port offset_valid, input, 1: single-cycle strobe qualifying offset_in.
REQ-012 Port offset_in, input, OFFSET_W: signed two's-complement slave-minus-master offset (o_deltaT format).
REQ-013 Port rate_adj_valid, output, 1: single-cycle strobe qualifying rate_adj.
REQ-014 Port rate_adj, output, ADJ_W: signed per-tick increment correction, in units of 2^-16 ns; held between strobes.
REQ-015 Port time_step_valid, output, 1: single-cycle strobe requesting a local-time step.
REQ-016 Port time_step, output, OFFSET_W: signed step value, equal to the negated offset.
REQ-017 Port locked, output, 1: servo lock indicator.
REQ-018 Port servo_state, output, 2: current state encoding, IDLE=0, TRACK=1, SETTLE=2.

Function
REQ-019 The servo is a fully pipelined design: it accepts a sample on every cycle, including back-to-back valid strobes.
REQ-020 Samples are registered in stage 1, and outputs are driven in stage 2.
REQ-021 Latency: when offset_valid is asserted in cycle N, the resulting strobe occurs in cycle N+2.
REQ-022 mag is |offset_in| >> 16, in ns.
REQ-023 If offset_in is the most negative value, mag saturates to all-ones.
REQ-024 State IDLE: no strobes, integrator=0, lock count=0, locked=0.
REQ-025 IDLE exits to TRACK on the first valid sample while servo_enable=1.
REQ-026 State TRACK, mag >= STEP_THRESH_NS: pulse time_step_valid with time_step=-offset_in, saturated to the maximum positive value for the most negative input.
REQ-027 TRACK step case, continued: clear the integrator, clear the lock count, drop locked, hold rate_adj, and go to SETTLE.
REQ-028 State TRACK, mag < STEP_THRESH_NS: P = offset_in >>> KP_SHIFT and integ = sat48(integ + (offset_in >>> KI_SHIFT)).
REQ-029 TRACK PI case, continued: rate_adj = sat_ADJ_W(-(P + integ)), then pulse rate_adj_valid.
REQ-030 All arithmetic is signed and saturating; it never wraps.
REQ-031 State SETTLE: each valid sample increments the settle counter and produces no output.
REQ-032 SETTLE returns to TRACK after SETTLE_CNT samples; the sample following the last discarded one is processed in TRACK.
REQ-033 Lock: in TRACK, a sample with mag < LOCK_THRESH_NS increments a saturating counter; any other sample clears it.
REQ-034 locked=1 when the lock counter is >= LOCK_CNT; locked updates in the same cycle as rate_adj_valid.
REQ-035 When servo_enable falls, the servo goes to IDLE on the next cycle, and in-flight stage-2 outputs are suppressed.
REQ-036 Boundary mag == STEP_THRESH_NS causes a step; mag == LOCK_THRESH_NS is not in-lock.
REQ-037 Simultaneous offset_valid and a servo_enable fall: the sample is dropped.
REQ-038 The servo never pulses time_step_valid and rate_adj_valid in the same cycle.

Reset
REQ-039 On reset assertion, all of the following clear asynchronously: state=IDLE, all strobes=0, rate_adj=0, time_step=0, locked=0, and the integrator, settle and lock counters.
REQ-040 Reset asserted mid-pipeline discards in-flight samples; no strobe appears after deassertion without a new offset_valid.
REQ-041 Deassertion is synchronous to syc_clk_250m; the first sample is accepted on the first rising edge with sys_reset_n=1.

Verification
REQ-042 Enable, then offset +50 ns (0x32_0000) -> cycle N+2: rate_adj_valid=1, rate_adj = -(0xC8000 + 0xC800) = -0xD4800.
REQ-043 Offset +5000 ns -> time_step_valid with time_step = -5000 ns; the next 2 samples yield no strobes; the 3rd yields rate_adj_valid.
REQ-044 Eight consecutive +10 ns samples -> locked=1 with the 8th rate_adj_valid; then one +200 ns sample -> locked=0.
REQ-045 Offset = 0x8000...0 -> time_step = 0x7FFF...F; a large offset that overflows ADJ_W -> rate_adj = 0x8000_0000 or 0x7FFF_FFFF.
REQ-046 Back-to-back valids at +1000 ns then +10 ns -> step at N+2, then nothing at N+3 (the sample is in SETTLE).
REQ-047 Reset pulse one cycle after offset_valid -> no strobe, all outputs 0, servo_state=0.

Source files
------------

// File: rtl/ptp_offset_servo.sv
// PTP offset servo: a two-stage pipelined PI loop that turns slave-minus-master
// offsets into per-tick rate corrections, or into time steps for large offsets.
module ptp_offset_servo #(
  parameter int OFFSET_W       = 80,
  parameter int ADJ_W          = 32,
  parameter int STEP_THRESH_NS = 1000,
  parameter int LOCK_THRESH_NS = 100,
  parameter int LOCK_CNT       = 8,
  parameter int SETTLE_CNT     = 2,
  parameter int KP_SHIFT       = 2,
  parameter int KI_SHIFT       = 6
) (
  input  logic                       syc_clk_250m,
  input  logic                       sys_reset_n,
  input  logic                       servo_enable,
  input  logic                       offset_valid,
  input  logic signed [OFFSET_W-1:0] offset_in,
  output logic                       rate_adj_valid,
  output logic signed [ADJ_W-1:0]    rate_adj,
  output logic                       time_step_valid,
  output logic signed [OFFSET_W-1:0] time_step,
  output logic                       locked,
  output logic [1:0]                 servo_state
);

  localparam int MAG_W    = OFFSET_W - 16;
  localparam int INTEG_W  = 48;
  localparam int EXT_W    = OFFSET_W + 3;
  localparam int LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CNT + 1);

  localparam logic signed [OFFSET_W-1:0] OFF_MIN = {1'b1, {(OFFSET_W-1){1'b0}}};
  localparam logic signed [OFFSET_W-1:0] OFF_MAX = {1'b0, {(OFFSET_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] INTEG_MAX_X = EXT_W'({1'b0, {(INTEG_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] INTEG_MIN_X = -INTEG_MAX_X - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] ADJ_MAX_X   = EXT_W'({1'b0, {(ADJ_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] ADJ_MIN_X   = -ADJ_MAX_X - EXT_W'(1);
  localparam logic [MAG_W-1:0]    STEP_MAG  = MAG_W'(STEP_THRESH_NS);
  localparam logic [MAG_W-1:0]    LOCK_MAG  = MAG_W'(LOCK_THRESH_NS);
  localparam logic [LOCK_W-1:0]   LOCK_SAT  = LOCK_W'(LOCK_CNT);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                     state;
  logic                       s1_valid;
  logic signed [OFFSET_W-1:0] s1_off;
  logic signed [INTEG_W-1:0]  integ;
  logic [LOCK_W-1:0]          lock_cnt;
  logic [SETTLE_W-1:0]        settle_cnt;

  logic                       is_min;
  logic signed [OFFSET_W-1:0] abs_off;
  logic [MAG_W-1:0]           mag;
  logic                       step_hit;
  logic signed [OFFSET_W-1:0] step_val;
  logic signed [EXT_W-1:0]    integ_sum;
  logic signed [INTEG_W-1:0]  integ_next;
  logic signed [EXT_W-1:0]    adj_wide;
  logic signed [ADJ_W-1:0]    adj_next;
  logic [LOCK_W-1:0]          lock_next;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    is_min   = (s1_off == OFF_MIN);
    abs_off  = s1_off[OFFSET_W-1] ? -s1_off : s1_off;
    mag      = is_min ? '1 : MAG_W'(abs_off >> 16);
    step_hit = (mag >= STEP_MAG);
    step_val = is_min ? OFF_MAX : -s1_off;

    // Integrator update; widened so the sum cannot wrap before clamping.
    integ_sum = EXT_W'(integ) + EXT_W'(s1_off >>> KI_SHIFT);
    if (integ_sum > INTEG_MAX_X)      integ_next = {1'b0, {(INTEG_W-1){1'b1}}};
    else if (integ_sum < INTEG_MIN_X) integ_next = {1'b1, {(INTEG_W-1){1'b0}}};
    else                              integ_next = INTEG_W'(integ_sum);

    adj_wide = -(EXT_W'(s1_off >>> KP_SHIFT) + EXT_W'(integ_next));
    if (adj_wide > ADJ_MAX_X)      adj_next = {1'b0, {(ADJ_W-1){1'b1}}};
    else if (adj_wide < ADJ_MIN_X) adj_next = {1'b1, {(ADJ_W-1){1'b0}}};
    else                           adj_next = ADJ_W'(adj_wide);

    if (mag < LOCK_MAG) lock_next = (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + LOCK_W'(1);
    else                lock_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge syc_clk_250m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state           <= ST_IDLE;
      s1_valid        <= 1'b0;
      s1_off          <= '0;
      integ           <= '0;
      lock_cnt        <= '0;
      settle_cnt      <= '0;
      rate_adj_valid  <= 1'b0;
      rate_adj        <= '0;
      time_step_valid <= 1'b0;
      time_step       <= '0;
      locked          <= 1'b0;
    end else begin
      // A sample arriving while disabled is dropped at capture.
      s1_valid        <= offset_valid && servo_enable;
      if (offset_valid) s1_off <= offset_in;
      rate_adj_valid  <= 1'b0;
      time_step_valid <= 1'b0;

      if (!servo_enable) begin
        state      <= ST_IDLE;
        integ      <= '0;
        lock_cnt   <= '0;
        settle_cnt <= '0;
        locked     <= 1'b0;
      end else if (s1_valid) begin
        case (state)
          ST_IDLE, ST_TRACK: begin
            if (step_hit) begin
              time_step_valid <= 1'b1;
              time_step       <= step_val;
              integ           <= '0;
              lock_cnt        <= '0;
              locked          <= 1'b0;
              settle_cnt      <= '0;
              state           <= ST_SETTLE;
            end else begin
              integ          <= integ_next;
              rate_adj       <= adj_next;
              rate_adj_valid <= 1'b1;
              lock_cnt       <= lock_next;
              locked         <= (lock_next >= LOCK_SAT);
              state          <= ST_TRACK;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= ST_TRACK;
            end else begin
              settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign servo_state = state;

endmodule

// File: tb/tb_ptp_offset_servo.sv
// Self-checking bench for ptp_offset_servo: a wide-integer behavioural model is
// compared with the DUT every cycle, plus hand-computed literal expectations.
module tb_ptp_offset_servo;

  localparam int OW = 80;
  localparam int AW = 32;
  localparam logic signed [OW-1:0] OFF_MIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [OW-1:0] OFF_MAX = {1'b0, {(OW-1){1'b1}}};

  typedef logic signed [127:0] wide_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en = 1'b0;
  logic                 ov = 1'b0;
  logic signed [OW-1:0] off = '0;
  logic                 rate_adj_valid;
  logic signed [AW-1:0] rate_adj;
  logic                 time_step_valid;
  logic signed [OW-1:0] time_step;
  logic                 locked;
  logic [1:0]           servo_state;

  int n_tests = 0;
  int n_fail  = 0;

  ptp_offset_servo #(
    .OFFSET_W(OW), .ADJ_W(AW), .STEP_THRESH_NS(1000), .LOCK_THRESH_NS(100),
    .LOCK_CNT(8), .SETTLE_CNT(2), .KP_SHIFT(2), .KI_SHIFT(6)
  ) dut (
    .syc_clk_250m   (clk),
    .sys_reset_n    (rst_n),
    .servo_enable   (en),
    .offset_valid   (ov),
    .offset_in      (off),
    .rate_adj_valid (rate_adj_valid),
    .rate_adj       (rate_adj),
    .time_step_valid(time_step_valid),
    .time_step      (time_step),
    .locked         (locked),
    .servo_state    (servo_state)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (plain wide integer arithmetic) ----------------
  int                   m_state  = 0;
  wide_t                m_integ  = 0;
  int                   m_lock   = 0;
  int                   m_settle = 0;
  bit                   m_locked = 0;
  bit                   m_rav    = 0;
  bit                   m_tsv    = 0;
  logic signed [AW-1:0] m_rate   = '0;
  logic signed [OW-1:0] m_ts     = '0;
  bit                   m_pv     = 0;
  logic signed [OW-1:0] m_poff   = '0;

  function automatic wide_t clamp(input wide_t v, input int bits);
    wide_t one, hi, lo;
    one = 1;
    hi  = (one <<< (bits - 1)) - 1;
    lo  = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t mag_ns(input logic signed [OW-1:0] o);
    wide_t w, one;
    one = 1;
    if (o == OFF_MIN) return (one <<< 64) - 1;
    w = o;
    if (w < 0) w = -w;
    return w >>> 16;
  endfunction

  task automatic model_sample(input logic signed [OW-1:0] v);
    wide_t w, mg, r;
    w  = v;
    mg = mag_ns(v);
    if (m_state == 0) m_state = 1;
    if (m_state == 1) begin
      if (mg >= 1000) begin
        m_tsv    = 1;
        r        = clamp(-w, OW);
        m_ts     = r[OW-1:0];
        m_integ  = 0;
        m_lock   = 0;
        m_locked = 0;
        m_settle = 0;
        m_state  = 2;
      end else begin
        m_integ  = clamp(m_integ + (w >>> 6), 48);
        r        = clamp(-((w >>> 2) + m_integ), AW);
        m_rate   = r[AW-1:0];
        m_rav    = 1;
        m_lock   = (mg < 100) ? ((m_lock < 8) ? m_lock + 1 : 8) : 0;
        m_locked = (m_lock >= 8);
      end
    end else begin
      m_settle++;
      if (m_settle == 2) begin
        m_settle = 0;
        m_state  = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_integ = 0; m_lock = 0; m_settle = 0; m_locked = 0;
      m_rav = 0; m_tsv = 0; m_rate = '0; m_ts = '0; m_pv = 0;
    end else begin
      m_rav = 0;
      m_tsv = 0;
      if (!en) begin
        m_state = 0; m_integ = 0; m_lock = 0; m_settle = 0; m_locked = 0; m_pv = 0;
      end else begin
        if (m_pv) model_sample(m_poff);
        m_pv   = ov;
        m_poff = off;
      end
    end
  end

  always @(negedge clk) begin
    check("rate_adj_valid", 128'(rate_adj_valid), 128'(m_rav));
    check("time_step_valid", 128'(time_step_valid), 128'(m_tsv));
    check("rate_adj", 128'($unsigned(rate_adj)), 128'($unsigned(m_rate)));
    check("locked", 128'(locked), 128'(m_locked));
    check("servo_state", 128'(servo_state), 128'(m_state));
    if (m_tsv || !rst_n) check("time_step", 128'($unsigned(time_step)), 128'($unsigned(m_ts)));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic signed [OW-1:0] mk(input int unsigned ns, input int unsigned frac, input bit neg);
    logic signed [OW-1:0] t;
    t = {48'd0, ns[15:0], frac[15:0]};
    return neg ? -t : t;
  endfunction

  function automatic logic signed [OW-1:0] rand_off();
    logic [95:0] r;
    bit          s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: begin r = {$urandom(), $urandom(), $urandom()}; return r[OW-1:0]; end
      1: return OFF_MIN;
      2: return mk(1000, 0, s);
      3: return mk(100, 0, s);
      4: return mk(999, 16'hFFFF, s);
      5, 6, 7: return mk($urandom_range(0, 150), $urandom_range(0, 65535), s);
      default: return mk($urandom_range(0, 1500), $urandom_range(0, 65535), s);
    endcase
  endfunction

  // Caller is just after a rising edge; returns just after the capturing edge.
  task automatic send(input logic signed [OW-1:0] v);
    ov  = 1'b1;
    off = v;
    @(posedge clk); #1;
    ov  = 1'b0;
  endtask

  // Moves to the sampling point where a sample sent just before is visible.
  task automatic to_out();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic signed [OW-1:0] exp_ts;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_state_lit", 128'(servo_state), 128'd0);
    check("idle_locked_lit", 128'(locked), 128'd0);
    @(posedge clk); #1 en = 1'b1;

    // +50 ns: first sample leaves IDLE and is processed as TRACK.
    send(80'sh32_0000);
    to_out();
    check("p50_valid_lit", 128'(rate_adj_valid), 128'd1);
    check("p50_adj_lit", 128'($unsigned(rate_adj)), 128'h0000_0000_0000_0000_0000_0000_FFF2_B800);
    check("p50_state_lit", 128'(servo_state), 128'd1);
    @(posedge clk); #1;

    // +5000 ns: step, two discarded samples, then a rate adjust.
    send(mk(5000, 0, 0));
    to_out();
    exp_ts = mk(5000, 0, 1);
    check("step_valid_lit", 128'(time_step_valid), 128'd1);
    check("step_val_lit", 128'($unsigned(time_step)), 128'($unsigned(exp_ts)));
    check("step_noadj_lit", 128'(rate_adj_valid), 128'd0);
    check("settle_state_lit", 128'(servo_state), 128'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      send(mk(10, 0, 0));
      to_out();
      check("settle_adj_lit", 128'(rate_adj_valid), (i == 2) ? 128'd1 : 128'd0);
      check("settle_step_lit", 128'(time_step_valid), 128'd0);
    end

    // Lock after eight +10 ns samples, lost on a +200 ns sample.
    @(posedge clk); #1;
    reset_pulse();
    for (int i = 1; i <= 8; i++) begin
      send(mk(10, 0, 0));
      to_out();
      check("lock_build_lit", 128'(locked), (i == 8) ? 128'd1 : 128'd0);
      @(posedge clk); #1;
    end
    send(mk(200, 0, 0));
    to_out();
    check("lock_lost_lit", 128'(locked), 128'd0);
    @(posedge clk); #1;

    // Most negative offset saturates the step.
    send(OFF_MIN);
    to_out();
    check("min_step_lit", 128'($unsigned(time_step)), 128'($unsigned(OFF_MAX)));
    @(posedge clk); #1;
    send(mk(1, 0, 0));
    send(mk(1, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back +1000 ns then +10 ns: step, then silence.
    ov = 1'b1; off = mk(1000, 0, 0);
    @(posedge clk); #1;
    off = mk(10, 0, 0);
    @(posedge clk); #1;
    ov = 1'b0;
    @(negedge clk);
    check("b2b_step_lit", 128'(time_step_valid), 128'd1);
    @(negedge clk);
    check("b2b_quiet_step_lit", 128'(time_step_valid), 128'd0);
    check("b2b_quiet_adj_lit", 128'(rate_adj_valid), 128'd0);
    @(posedge clk); #1;

    // Sample and enable fall together: dropped, servo idles.
    ov = 1'b1; en = 1'b0; off = mk(20, 0, 0);
    @(posedge clk); #1;
    ov = 1'b0; en = 1'b1;
    to_out();
    check("drop_adj_lit", 128'(rate_adj_valid), 128'd0);
    @(posedge clk); #1;

    // Reset one cycle after a sample: nothing comes out.
    send(mk(50, 0, 0));
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_adj_valid_lit", 128'(rate_adj_valid), 128'd0);
      check("rst_step_valid_lit", 128'(time_step_valid), 128'd0);
      check("rst_adj_lit", 128'($unsigned(rate_adj)), 128'd0);
      check("rst_step_lit", 128'($unsigned(time_step)), 128'd0);
      check("rst_state_lit", 128'(servo_state), 128'd0);
    end
    @(posedge clk); #1;

    // Randomised traffic with enable drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ov  = ($urandom_range(0, 99) < 60);
      en  = ($urandom_range(0, 99) < 96);
      off = rand_off();
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    ov = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // Integrator windup drives rate_adj into both saturation limits.
    reset_pulse();
    ov = 1'b1; off = mk(999, 0, 0);
    repeat (2200) @(posedge clk);
    #1 ov = 1'b0;
    to_out();
    check("sat_neg_lit", 128'($unsigned(rate_adj)), 128'h8000_0000);
    @(posedge clk); #1;
    ov = 1'b1; off = mk(999, 0, 1);
    repeat (4400) @(posedge clk);
    #1 ov = 1'b0;
    to_out();
    check("sat_pos_lit", 128'($unsigned(rate_adj)), 128'h7FFF_FFFF);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
